alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have parameter: RADDR, 5, register-address width.
REQ-003 SHALL have ports: clk  in  1  clock, rising-edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: id_valid  in  1  decode offers instruction; id_ready  out  1  stage accepts.
REQ-005 SHALL have ports: id_rs, id_rt  in  RADDR  source regs; id_rsval, id_rtval  in  WIDTH  regfile values.
REQ-006 SHALL have ports: id_imm  in  WIDTH  immediate; id_useimm  in  1  b from immediate.
REQ-007 SHALL have ports: id_op  in  3  ALU op code; id_unsig  in  1  unsigned flag; id_rd  in  RADDR  dest; id_wen  in  1  writes dest.
REQ-008 SHALL have ports: flush  in  1  squash held/incoming instruction.
REQ-009 SHALL have ports: exmem_rd  in  RADDR; exmem_wen  in  1; exmem_val  in  WIDTH  EX/MEM result.
REQ-010 SHALL have ports: memwb_rd  in  RADDR; memwb_wen  in  1; memwb_val  in  WIDTH  MEM/WB result.
REQ-011 SHALL have ports: ex_valid  out  1; ex_ready  in  1  Alu/EX-MEM accepts.
REQ-012 SHALL have ports: a, b  out  WIDTH; op  out  3; unsig  out  1; ex_rd  out  RADDR; ex_wen  out  1.

Function
REQ-013 SHALL be a single-entry registered stage; a, b, op, unsig, ex_rd, ex_wen held stable while ex_valid=1 and ex_ready=0.
REQ-014 SHALL define transfer-in as id_valid & id_ready, transfer-out as ex_valid & ex_ready, both sampled at clk rise.
REQ-015 SHALL drive id_ready = (!ex_valid | ex_ready) & !stall, combinationally.
REQ-016 SHALL treat rs as used always; rt used only when id_useimm=0.
REQ-017 SHALL assert stall when a used source != 0 matches ex_rd with ex_valid & ex_wen (result not yet produced).
REQ-018 SHALL resolve operand a at capture: exmem_val if exmem_wen & exmem_rd==id_rs & id_rs!=0; else memwb_val on same rule for memwb; else id_rsval.
REQ-019 SHALL resolve b the same way for id_rt, or take id_imm when id_useimm=1.
REQ-020 SHALL never forward or stall on register 0.
REQ-021 SHALL set ex_valid next cycle on transfer-in; clear it on transfer-out without simultaneous transfer-in; back-to-back transfer in/out gives full throughput.
REQ-022 SHALL, on flush=1, clear ex_valid next cycle and discard any same-cycle transfer-in (flush wins).
REQ-023 SHALL pass op, unsig, rd, wen unmodified; latency id->ex exactly 1 cycle.

Reset
REQ-024 SHALL, on rst_n=0 (asynchronous, any cycle incl. mid-stall), force ex_valid=0, a=b=0, op=000, unsig=0, ex_rd=0, ex_wen=0.
REQ-025 SHALL drive id_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-026 SHALL honour macro ALU_ISSUE_FORWARDING_EN: defined -> REQ-018/019 bypass active.
REQ-027 SHALL, without ALU_ISSUE_FORWARDING_EN, take regfile values only and extend stall to exmem and memwb matches of used non-zero sources.

Structure
REQ-028 SHALL place ALU op encodings (AND 000, OR 001, ADD 010, NOR 100, XOR 101, SUB 110) and WIDTH/RADDR defaults in shared package alu_pkg.
REQ-029 SHALL use one sub-module alu_fwd_mux (per-operand bypass select), instantiated twice.

Verification
REQ-030 SHALL cover: reset mid-hold, ex_valid=1 -> outputs zero immediately, id_ready=1 after release.
REQ-031 SHALL cover: rs=3, exmem_rd=3 wen=1 val=0x11, memwb_rd=3 val=0x22 -> a=0x11 (EX/MEM priority).
REQ-032 SHALL cover: rs=0, exmem_rd=0 wen=1 val=0xFF, id_rsval=0 -> a=0, no stall.
REQ-033 SHALL cover: ex_valid=1 ex_rd=5 ex_wen=1, incoming rt=5 useimm=0 -> id_ready=0 one cycle; with useimm=1 -> accepted, b=id_imm.
REQ-034 SHALL cover: ex_ready=0 for 3 cycles holding a=0xDEADBEEF op=110 -> outputs unchanged; flush then -> ex_valid=0 next cycle.
REQ-035 SHALL cover: 8 consecutive id_valid with ex_ready=1, no hazards -> 8 transfers in 8 cycles, op order preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings and default operand/register widths.
// Imported by alu_fwd_mux and alu_issue.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int RADDR_DEF = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SUB = 3'b110
  } alu_op_e;

endpackage

// File: rtl/alu_fwd_mux.sv
// Per-operand bypass select and pipeline-match detection.
// ALU_ISSUE_FORWARDING_EN enables the EX/MEM and MEM/WB bypass paths.
module alu_fwd_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic [RADDR-1:0] src,
  input  logic             used,
  input  logic [WIDTH-1:0] regval,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic             exmem_wen,
  input  logic [WIDTH-1:0] exmem_val,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic             memwb_wen,
  input  logic [WIDTH-1:0] memwb_val,
  output logic [WIDTH-1:0] val,
  output logic             hit_ex,
  output logic             hit_wb
);

  logic nz;

  assign nz     = (src != '0) & used;
  assign hit_ex = nz & exmem_wen & (exmem_rd == src);
  assign hit_wb = nz & memwb_wen & (memwb_rd == src);

`ifdef ALU_ISSUE_FORWARDING_EN
  always_comb begin
    val = regval;
    if (hit_ex)      val = exmem_val;
    else if (hit_wb) val = memwb_val;
  end
`else
  logic unused_vals;
  assign unused_vals = ^{exmem_val, memwb_val};
  assign val = regval;
`endif

endmodule

// File: rtl/alu_issue.sv
// Single-entry ALU issue stage: hazard stall, operand select, EX handoff.
// ALU_ISSUE_FORWARDING_EN selects bypass; otherwise pipeline matches stall.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [WIDTH-1:0] id_rsval,
  input  logic [WIDTH-1:0] id_rtval,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_useimm,
  input  logic [2:0]       id_op,
  input  logic             id_unsig,
  input  logic [RADDR-1:0] id_rd,
  input  logic             id_wen,
  input  logic             flush,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic             exmem_wen,
  input  logic [WIDTH-1:0] exmem_val,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic             memwb_wen,
  input  logic [WIDTH-1:0] memwb_val,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       op,
  output logic             unsig,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_wen
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             unsig_q, unsig_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic             wen_q, wen_d;

  logic             use_rt;
  logic [WIDTH-1:0] rs_fwd, rt_fwd;
  logic             rs_hex, rs_hwb;
  logic             rt_hex, rt_hwb;
  logic             ex_live;
  logic             ex_hit;
  logic             stall;
  logic             xfer_in, xfer_out;

  assign use_rt = ~id_useimm;

  alu_fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_a (
    .src       (id_rs),
    .used      (1'b1),
    .regval    (id_rsval),
    .exmem_rd  (exmem_rd),
    .exmem_wen (exmem_wen),
    .exmem_val (exmem_val),
    .memwb_rd  (memwb_rd),
    .memwb_wen (memwb_wen),
    .memwb_val (memwb_val),
    .val       (rs_fwd),
    .hit_ex    (rs_hex),
    .hit_wb    (rs_hwb)
  );

  alu_fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_b (
    .src       (id_rt),
    .used      (use_rt),
    .regval    (id_rtval),
    .exmem_rd  (exmem_rd),
    .exmem_wen (exmem_wen),
    .exmem_val (exmem_val),
    .memwb_rd  (memwb_rd),
    .memwb_wen (memwb_wen),
    .memwb_val (memwb_val),
    .val       (rt_fwd),
    .hit_ex    (rt_hex),
    .hit_wb    (rt_hwb)
  );

  // The held instruction's result does not exist yet, so no bypass helps.
  assign ex_live = valid_q & wen_q & (rd_q != '0);
  assign ex_hit  = ex_live &
                   ((id_rs == rd_q) | (use_rt & (id_rt == rd_q)));

`ifdef ALU_ISSUE_FORWARDING_EN
  logic unused_hits;
  assign unused_hits = ^{rs_hex, rs_hwb, rt_hex, rt_hwb};
  assign stall = ex_hit;
`else
  assign stall = ex_hit | rs_hex | rs_hwb | rt_hex | rt_hwb;
`endif

  assign id_ready = (~valid_q | ex_ready) & ~stall;
  assign xfer_in  = id_valid & id_ready;
  assign xfer_out = valid_q & ex_ready;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unsig_d = unsig_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer_in) begin
      valid_d = 1'b1;
      a_d     = rs_fwd;
      b_d     = id_useimm ? id_imm : rt_fwd;
      op_d    = id_op;
      unsig_d = id_unsig;
      rd_d    = id_rd;
      wen_d   = id_wen;
    end else if (xfer_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      unsig_q <= 1'b0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      unsig_q <= unsig_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
    end
  end

  assign ex_valid = valid_q;
  assign a        = a_q;
  assign b        = b_q;
  assign op       = op_q;
  assign unsig    = unsig_q;
  assign ex_rd    = rd_q;
  assign ex_wen   = wen_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: hazards, bypass/stall, hold, flush, reset.
// Honours ALU_ISSUE_FORWARDING_EN for the EX/MEM vs MEM/WB vectors.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rsval, id_rtval, id_imm;
  logic        id_useimm, id_unsig, id_wen;
  logic [2:0]  id_op;
  logic        flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_wen, memwb_wen;
  logic [31:0] exmem_val, memwb_val;
  logic        ex_valid, ex_ready;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        unsig;
  logic [4:0]  ex_rd;
  logic        ex_wen;

  int n_run  = 0;
  int n_fail = 0;
  int xfers  = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rsval  (id_rsval),
    .id_rtval  (id_rtval),
    .id_imm    (id_imm),
    .id_useimm (id_useimm),
    .id_op     (id_op),
    .id_unsig  (id_unsig),
    .id_rd     (id_rd),
    .id_wen    (id_wen),
    .flush     (flush),
    .exmem_rd  (exmem_rd),
    .exmem_wen (exmem_wen),
    .exmem_val (exmem_val),
    .memwb_rd  (memwb_rd),
    .memwb_wen (memwb_wen),
    .memwb_val (memwb_val),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .unsig     (unsig),
    .ex_rd     (ex_rd),
    .ex_wen    (ex_wen)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0]  o,
                       input logic [4:0]  rs,
                       input logic [4:0]  rt,
                       input logic [31:0] rsv,
                       input logic [31:0] rtv,
                       input logic [31:0] imm,
                       input logic        ui,
                       input logic [4:0]  rd,
                       input logic        wen);
    id_valid  = 1'b1;
    id_op     = o;
    id_rs     = rs;
    id_rt     = rt;
    id_rsval  = rsv;
    id_rtval  = rtv;
    id_imm    = imm;
    id_useimm = ui;
    id_rd     = rd;
    id_wen    = wen;
    id_unsig  = 1'b0;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] ops [8];

  initial begin
    ops = '{3'b000, 3'b001, 3'b010, 3'b100,
            3'b101, 3'b110, 3'b000, 3'b010};
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_rsval = '0; id_rtval = '0; id_imm = '0;
    id_useimm = 1'b0; id_unsig = 1'b0; id_wen = 1'b0; id_op = '0;
    flush = 1'b0; ex_ready = 1'b1;
    exmem_rd = '0; exmem_wen = 1'b0; exmem_val = '0;
    memwb_rd = '0; memwb_wen = 1'b0; memwb_val = '0;

    tick;
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_a", a, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'b0, id_ready}, 32'd1);

    // basic register-register transfer, 1-cycle latency
    drive(ALU_ADD, 5'd1, 5'd2, 32'h10, 32'h20, 32'h0, 1'b0, 5'd4, 1'b1);
    chk("basic_rdy", {31'b0, id_ready}, 32'd1);
    tick;
    id_valid = 1'b0;
    chk("basic_v", {31'b0, ex_valid}, 32'd1);
    chk("basic_a", a, 32'h10);
    chk("basic_b", b, 32'h20);
    chk("basic_op", {29'b0, op}, 32'd2);
    chk("basic_rd", {27'b0, ex_rd}, 32'd4);
    chk("basic_wen", {31'b0, ex_wen}, 32'd1);
    tick;
    chk("basic_drain", {31'b0, ex_valid}, 32'd0);

    // load-use style hazard on rt against held ex_rd=5
    drive(ALU_AND, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 5'd5, 1'b1);
    tick;
    chk("prod_rd", {27'b0, ex_rd}, 32'd5);
    drive(ALU_OR, 5'd1, 5'd5, 32'hA, 32'hB, 32'h0, 1'b0, 5'd5, 1'b1);
    chk("stall_rt", {31'b0, id_ready}, 32'd0);
    tick;
    chk("stall_drain", {31'b0, ex_valid}, 32'd0);
    chk("stall_free", {31'b0, id_ready}, 32'd1);
    tick;
    chk("stall_b", b, 32'hB);
    chk("stall_op", {29'b0, op}, 32'd1);
    drive(ALU_XOR, 5'd1, 5'd5, 32'hA, 32'hB, 32'h1234, 1'b1, 5'd6, 1'b1);
    chk("imm_rdy", {31'b0, id_ready}, 32'd1);
    tick;
    id_valid = 1'b0;
    chk("imm_b", b, 32'h1234);
    chk("imm_op", {29'b0, op}, 32'd5);
    chk("imm_rd", {27'b0, ex_rd}, 32'd6);
    tick;

    // hold under backpressure, then flush beats an incoming transfer
    ex_ready = 1'b0;
    drive(ALU_SUB, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0, 32'h1, 1'b1, 5'd8, 1'b1);
    tick;
    id_valid = 1'b0;
    chk("hold_a0", a, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_a", a, 32'hDEADBEEF);
      chk("hold_op", {29'b0, op}, 32'd6);
      chk("hold_v", {31'b0, ex_valid}, 32'd1);
      chk("hold_rdy", {31'b0, id_ready}, 32'd0);
    end
    drive(ALU_ADD, 5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 1'b0, 5'd9, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    id_valid = 1'b0;
    chk("flush_v", {31'b0, ex_valid}, 32'd0);
    ex_ready = 1'b1;

    // EX/MEM and MEM/WB both match rs=3
    exmem_rd = 5'd3; exmem_wen = 1'b1; exmem_val = 32'h11;
    memwb_rd = 5'd3; memwb_wen = 1'b1; memwb_val = 32'h22;
    drive(ALU_ADD, 5'd3, 5'd0, 32'h33, 32'h0, 32'h0, 1'b1, 5'd10, 1'b1);
`ifdef ALU_ISSUE_FORWARDING_EN
    chk("fwd_rdy", {31'b0, id_ready}, 32'd1);
    tick;
    chk("fwd_exmem", a, 32'h11);
    exmem_wen = 1'b0;
    #1;
    tick;
    id_valid = 1'b0;
    chk("fwd_memwb", a, 32'h22);
`else
    chk("nofwd_stall_ex", {31'b0, id_ready}, 32'd0);
    exmem_wen = 1'b0;
    #1;
    chk("nofwd_stall_wb", {31'b0, id_ready}, 32'd0);
    memwb_wen = 1'b0;
    #1;
    chk("nofwd_rdy", {31'b0, id_ready}, 32'd1);
    tick;
    id_valid = 1'b0;
    chk("nofwd_a", a, 32'h33);
`endif
    exmem_wen = 1'b0;
    memwb_wen = 1'b0;
    tick;

    // register 0 never forwards or stalls
    exmem_rd = 5'd0; exmem_wen = 1'b1; exmem_val = 32'hFF;
    drive(ALU_ADD, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd11, 1'b1);
    chk("r0_rdy", {31'b0, id_ready}, 32'd1);
    tick;
    id_valid = 1'b0;
    chk("r0_a", a, 32'h0);
    exmem_wen = 1'b0;
    drive(ALU_AND, 5'd1, 5'd0, 32'h1, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1);
    tick;
    drive(ALU_OR, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1, 1'b1);
    chk("r0_ex_rdy", {31'b0, id_ready}, 32'd1);
    tick;
    id_valid = 1'b0;
    tick;

    // back-to-back stream: one transfer per cycle, order kept
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], 5'd0, 5'd0, 32'h0, 32'h0, 32'h100 + i,
            1'b1, 5'(i + 1), 1'b1);
      chk("bb_rdy", {31'b0, id_ready}, 32'd1);
      if (id_valid && id_ready) xfers++;
      tick;
      chk("bb_op", {29'b0, op}, {29'b0, ops[i]});
      chk("bb_b", b, 32'h100 + i);
      chk("bb_v", {31'b0, ex_valid}, 32'd1);
    end
    id_valid = 1'b0;
    chk("bb_count", xfers, 32'd8);
    tick;
    chk("bb_drain", {31'b0, ex_valid}, 32'd0);

    // asynchronous reset while holding
    ex_ready = 1'b0;
    drive(ALU_NOR, 5'd4, 5'd0, 32'hCAFE, 32'h0, 32'h55, 1'b1, 5'd12, 1'b1);
    tick;
    id_valid = 1'b0;
    chk("mid_v", {31'b0, ex_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_v", {31'b0, ex_valid}, 32'd0);
    chk("arst_a", a, 32'h0);
    chk("arst_b", b, 32'h0);
    chk("arst_op", {29'b0, op}, 32'd0);
    chk("arst_rd", {27'b0, ex_rd}, 32'd0);
    chk("arst_wen", {31'b0, ex_wen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rdy", {31'b0, id_ready}, 32'd1);
    tick;
    chk("arst_v2", {31'b0, ex_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
